// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: captures retired instruction records into a
// sequence-tagged FIFO and drains them over a valid/ready trace stream.
module retire_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int SEQ_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     retire_valid_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  input  logic                     mem_wrt_i,
  input  logic                     clear_i,
  output logic                     trc_valid_o,
  input  logic                     trc_ready_i,
  output logic [SEQ_W-1:0]         trc_seq_o,
  output logic [XLEN-1:0]          trc_pc_o,
  output logic [XLEN-1:0]          trc_instr_o,
  output logic [4:0]               trc_rd_o,
  output logic [XLEN-1:0]          trc_rd_data_o,
  output logic [XLEN-1:0]          trc_mem_addr_o,
  output logic [XLEN-1:0]          trc_mem_data_o,
  output logic                     trc_mem_wrt_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [SEQ_W-1:0]         drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic [4:0]       rd;
    logic [XLEN-1:0]  rd_data;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_data;
    logic             mem_wrt;
  } rec_t;

  rec_t             r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [SEQ_W-1:0] r_seq;
  logic [SEQ_W-1:0] r_drop;
  logic             r_ovf;

  logic w_cap;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  rec_t w_rec;
  rec_t w_head;

  assign w_cap  = retire_valid_i && (instr_i != '0);
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = (r_count != '0) && trc_ready_i;
  // A full FIFO still accepts when the head leaves on the same edge
  assign w_push = w_cap && (!w_full || w_pop);
  assign w_drop = w_cap && w_full && !w_pop;

  always_comb begin
    w_rec          = '0;
    w_rec.seq      = r_seq;
    w_rec.pc       = pc_i;
    w_rec.instr    = instr_i;
    w_rec.rd       = reg_addr_i;
    w_rec.mem_wrt  = mem_wrt_i;
    if (reg_addr_i != '0) begin
      w_rec.rd_data = reg_data_i;
    end
    if (mem_wrt_i) begin
      w_rec.mem_addr = mem_addr_i;
      w_rec.mem_data = mem_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !clear_i) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_seq    <= '0;
      r_drop   <= '0;
      r_ovf    <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_seq    <= '0;
      r_drop   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_cap) begin
        r_seq <= r_seq + SEQ_W'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != '1) begin
          r_drop <= r_drop + SEQ_W'(1);
        end
      end
    end
  end

  // Stale array contents are masked so an empty buffer presents zeros
  always_comb begin
    w_head = '0;
    if (r_count != '0) begin
      w_head = r_mem[r_rd_ptr];
    end
  end

  assign trc_valid_o    = (r_count != '0);
  assign trc_seq_o      = w_head.seq;
  assign trc_pc_o       = w_head.pc;
  assign trc_instr_o    = w_head.instr;
  assign trc_rd_o       = w_head.rd;
  assign trc_rd_data_o  = w_head.rd_data;
  assign trc_mem_addr_o = w_head.mem_addr;
  assign trc_mem_data_o = w_head.mem_data;
  assign trc_mem_wrt_o  = w_head.mem_wrt;
  assign count_o        = r_count;
  assign overflow_o     = r_ovf;
  assign drop_cnt_o     = r_drop;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer: directed vector table plus hand-written
// sequences for fill, overflow, simultaneous push/pop, clear and reset.
module tb_retire_trace_buffer;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        retire_valid_i;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [4:0]  reg_addr_i;
  logic [31:0] reg_data_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic        mem_wrt_i;
  logic        clear_i;
  logic        trc_valid_o;
  logic        trc_ready_i;
  logic [31:0] trc_seq_o;
  logic [31:0] trc_pc_o;
  logic [31:0] trc_instr_o;
  logic [4:0]  trc_rd_o;
  logic [31:0] trc_rd_data_o;
  logic [31:0] trc_mem_addr_o;
  logic [31:0] trc_mem_data_o;
  logic        trc_mem_wrt_o;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic [31:0] drop_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  retire_trace_buffer #(.XLEN(32), .DEPTH(16), .SEQ_W(32)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .retire_valid_i (retire_valid_i),
    .instr_i        (instr_i),
    .pc_i           (pc_i),
    .reg_addr_i     (reg_addr_i),
    .reg_data_i     (reg_data_i),
    .mem_addr_i     (mem_addr_i),
    .mem_data_i     (mem_data_i),
    .mem_wrt_i      (mem_wrt_i),
    .clear_i        (clear_i),
    .trc_valid_o    (trc_valid_o),
    .trc_ready_i    (trc_ready_i),
    .trc_seq_o      (trc_seq_o),
    .trc_pc_o       (trc_pc_o),
    .trc_instr_o    (trc_instr_o),
    .trc_rd_o       (trc_rd_o),
    .trc_rd_data_o  (trc_rd_data_o),
    .trc_mem_addr_o (trc_mem_addr_o),
    .trc_mem_data_o (trc_mem_data_o),
    .trc_mem_wrt_o  (trc_mem_wrt_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  typedef struct {
    logic        rv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rdd;
    logic [31:0] ma;
    logic [31:0] md;
    logic        mw;
    logic        clr;
    logic        rdy;
    logic        e_v;
    logic [31:0] e_seq;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [4:0]  e_rd;
    logic [31:0] e_rdd;
    logic [31:0] e_ma;
    logic [31:0] e_md;
    logic        e_mw;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drv(input logic rv, input logic [31:0] ins,
                     input logic [31:0] pc, input logic [4:0] rd,
                     input logic [31:0] rdd, input logic [31:0] ma,
                     input logic [31:0] md, input logic mw);
    retire_valid_i = rv;
    instr_i        = ins;
    pc_i           = pc;
    reg_addr_i     = rd;
    reg_data_i     = rdd;
    mem_addr_i     = ma;
    mem_data_i     = md;
    mem_wrt_i      = mw;
  endtask

  task automatic idle();
    drv(1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{1, 32'h00500093, 32'h0, 1, 5, 0, 0, 0, 0, 1,
                 1, 0, 32'h0, 32'h00500093, 1, 5, 0, 0, 0, 1};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 32'h00a00113, 32'h4, 2, 10, 0, 0, 0, 1, 1,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 32'h8, 3, 7, 0, 0, 0, 0, 1,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = vecs[3];
    vecs[5]  = vecs[3];
    vecs[6]  = '{1, 32'h002081b3, 32'hC, 3, 7, 32'h44, 32'h55, 0, 0, 0,
                 1, 0, 32'hC, 32'h002081b3, 3, 7, 0, 0, 0, 1};
    vecs[7]  = '{1, 32'h00112023, 32'h10, 0, 32'h55, 32'h100,
                 32'hDEADBEEF, 1, 0, 0,
                 1, 0, 32'hC, 32'h002081b3, 3, 7, 0, 0, 0, 2};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                 1, 1, 32'h10, 32'h00112023, 0, 0, 32'h100,
                 32'hDEADBEEF, 1, 1};
    vecs[9]  = '{1, 32'h00900293, 32'h14, 5, 9, 32'h200, 32'h11, 0, 0, 1,
                 1, 2, 32'h14, 32'h00900293, 5, 9, 0, 0, 0, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    rstn_i = 1'b0;
    clear_i = 1'b0;
    trc_ready_i = 1'b0;
    idle();
    repeat (3) step();
    chk("rst_valid", trc_valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    chk("rst_pc", trc_pc_o, 0);
    rstn_i = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      drv(vecs[i].rv, vecs[i].instr, vecs[i].pc, vecs[i].rd,
          vecs[i].rdd, vecs[i].ma, vecs[i].md, vecs[i].mw);
      clear_i = vecs[i].clr;
      trc_ready_i = vecs[i].rdy;
      step();
      chk($sformatf("v%0d_valid", i), trc_valid_o, vecs[i].e_v);
      chk($sformatf("v%0d_seq", i), trc_seq_o, vecs[i].e_seq);
      chk($sformatf("v%0d_pc", i), trc_pc_o, vecs[i].e_pc);
      chk($sformatf("v%0d_instr", i), trc_instr_o, vecs[i].e_instr);
      chk($sformatf("v%0d_rd", i), trc_rd_o, vecs[i].e_rd);
      chk($sformatf("v%0d_rdd", i), trc_rd_data_o, vecs[i].e_rdd);
      chk($sformatf("v%0d_maddr", i), trc_mem_addr_o, vecs[i].e_ma);
      chk($sformatf("v%0d_mdata", i), trc_mem_data_o, vecs[i].e_md);
      chk($sformatf("v%0d_mwrt", i), trc_mem_wrt_o, vecs[i].e_mw);
      chk($sformatf("v%0d_count", i), count_o, vecs[i].e_cnt);
    end
    clear_i = 1'b0;
    idle();

    // 18 retires into a stalled FIFO: two drops
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    trc_ready_i = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drv(1'b1, 32'h1000_0000 + 32'(i), 32'(i * 4), 5'd1, 32'(i),
          '0, '0, 1'b0);
      step();
    end
    idle();
    chk("ovf_count", count_o, 16);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_drop", drop_cnt_o, 2);
    chk("ovf_head_seq", trc_seq_o, 0);
    repeat (3) step();
    chk("stall_valid", trc_valid_o, 1);
    chk("stall_seq", trc_seq_o, 0);
    chk("stall_instr", trc_instr_o, 32'h1000_0000);
    trc_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain1_seq%0d", k), trc_seq_o, 64'(k));
      chk($sformatf("drain1_pc%0d", k), trc_pc_o, 64'(k * 4));
      step();
    end
    chk("drain1_empty", trc_valid_o, 0);
    chk("drain1_count", count_o, 0);

    // full FIFO with simultaneous push and pop
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("clr_ovf", overflow_o, 0);
    chk("clr_drop", drop_cnt_o, 0);
    trc_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 32'h2000_0000 + 32'(i), 32'h100 + 32'(i * 4), 5'd2,
          32'(i), '0, '0, 1'b0);
      step();
    end
    chk("fill_count", count_o, 16);
    drv(1'b1, 32'h2000_00FF, 32'h500, 5'd2, 32'h77, '0, '0, 1'b0);
    trc_ready_i = 1'b1;
    step();
    idle();
    trc_ready_i = 1'b0;
    chk("pp_count", count_o, 16);
    chk("pp_ovf", overflow_o, 0);
    chk("pp_drop", drop_cnt_o, 0);
    chk("pp_head", trc_seq_o, 1);
    trc_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain2_seq%0d", k), trc_seq_o, 64'(k + 1));
      chk($sformatf("drain2_pc%0d", k), trc_pc_o,
          (k < 15) ? 64'(32'h100 + 32'((k + 1) * 4)) : 64'h500);
      step();
    end
    chk("drain2_empty", trc_valid_o, 0);

    // clear during a capture after overflow
    trc_ready_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drv(1'b1, 32'h3000_0000 + 32'(i), 32'(i), 5'd0, '0, '0, '0, 1'b0);
      step();
    end
    chk("ovf2_flag", overflow_o, 1);
    chk("ovf2_drop", drop_cnt_o, 1);
    clear_i = 1'b1;
    drv(1'b1, 32'h3000_00AA, 32'h900, 5'd4, 32'h4, '0, '0, 1'b0);
    step();
    clear_i = 1'b0;
    idle();
    chk("clr2_count", count_o, 0);
    chk("clr2_valid", trc_valid_o, 0);
    chk("clr2_ovf", overflow_o, 0);
    chk("clr2_drop", drop_cnt_o, 0);
    drv(1'b1, 32'h3000_00BB, 32'hA00, 5'd4, 32'h4, '0, '0, 1'b0);
    step();
    idle();
    chk("post_clr_valid", trc_valid_o, 1);
    chk("post_clr_seq", trc_seq_o, 0);
    chk("post_clr_pc", trc_pc_o, 32'hA00);

    // async reset mid-drain
    drv(1'b1, 32'h3000_00CC, 32'hA04, 5'd4, 32'h5, '0, '0, 1'b0);
    step();
    idle();
    trc_ready_i = 1'b1;
    step();
    chk("mid_valid", trc_valid_o, 1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("arst_valid", trc_valid_o, 0);
    chk("arst_count", count_o, 0);
    chk("arst_pc", trc_pc_o, 0);
    step();
    rstn_i = 1'b1;
    drv(1'b1, 32'h3000_00DD, 32'hB00, 5'd1, 32'h1, '0, '0, 1'b0);
    trc_ready_i = 1'b0;
    step();
    idle();
    chk("post_rst_seq", trc_seq_o, 0);
    chk("post_rst_count", count_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
